// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential calculator.
package calc_pkg;

   // Operation selected by a button edge.
   typedef enum logic [2:0] {CLR, ADD, MUL, DIV, MOD} op_t;

   // Control states of the calculator.
   typedef enum logic [1:0] {IDLE, COMPUTE, CONVERT, DONE} state_t;

   // Digit shown in every BCD position while err is set.
   localparam logic [3:0] ERR_DIGIT = 4'hF;

   // 10^n as a 64-bit constant; used to find the largest displayable magnitude.
   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter for a 2*WIDTH-bit magnitude.
// A start pulse loads bin and performs the first step in the same cycle; the
// conversion takes exactly 2*WIDTH cycles including the start cycle. done is
// high in the cycle whose clock edge completes the last step, and bcd always
// shows the result of the step being taken in the current cycle, so bcd is
// the final value whenever done is high. Digits beyond DIGITS are discarded.
module bin2bcd
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  start,
   input  logic [2*WIDTH-1:0]    bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done
);

   localparam int unsigned BW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(BW + 1);

   logic [BW-1:0]          bin_q, bin_src, bin_nx;
   logic [4*DIGITS-1:0]    bcd_q, bcd_src, bcd_adj;
   logic [4*DIGITS+BW-1:0] shreg;
   logic [CW-1:0]          cnt_q;
   logic                   run_q;

   // One double-dabble step: add 3 to digits >= 5, then shift left by one.
   always_comb begin
      bin_src = start ? bin : bin_q;
      bcd_src = start ? '0 : bcd_q;
      bcd_adj = bcd_src;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_src[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_src[4*i +: 4] + 4'd3;
      end
      shreg  = {bcd_adj, bin_src} << 1;
      bcd    = shreg[4*DIGITS+BW-1:BW];
      bin_nx = shreg[BW-1:0];
   end

   assign done = run_q && (cnt_q == CW'(BW - 1));

   // Step registers and step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (clear) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         bin_q <= bin_nx;
         bcd_q <= bcd;
         cnt_q <= CW'(1);
         run_q <= 1'b1;
      end else if (run_q) begin
         bin_q <= bin_nx;
         bcd_q <= bcd;
         cnt_q <= cnt_q + 1'b1;
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_calculator.sv
// Sequential signed calculator: add, multiply, divide and modulo on WIDTH-bit
// two's complement operands, result shown as DIGITS BCD magnitude digits plus
// a sign flag. Operations start on button rising edges.
// Optional feature: define CALC_AUTO_RECALC_EN to rerun the last operation
// automatically when a or b changes while idle.
module seq_calculator
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   input  logic [4:0]                button,
   output logic [4*DIGITS-1:0]       bcd,
   output logic                      neg,
   output logic                      err,
   output logic                      busy,
   output logic                      valid
);

   localparam int unsigned BW    = 2 * WIDTH;
   localparam int unsigned CW    = $clog2(BW + 1);
   localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

   state_t state_q, state_d;

   logic [4:0] btn_q, edges;
   logic       armed_q;
   logic       clr_edge, op_start, start;
   op_t        op_sel, op_q;

   logic signed [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0]        ma, mb;
   logic [CW-1:0]           cnt_q;
   logic [BW-1:0]           acc_q, mcand_q, acc_nx;
   logic [WIDTH-1:0]        mplier_q, quot_q, rem_q, dvsr_q;
   logic [WIDTH:0]          rem_sh, diff, sum, sum_mag;
   logic                    dz, compute_last;

   logic [BW-1:0]        conv_bin;
   logic [4*DIGITS-1:0]  conv_bcd;
   logic                 conv_start, conv_done, res_neg, res_err;

   logic [4*DIGITS-1:0]  bcd_q;
   logic                 neg_q, err_q;

`ifdef CALC_AUTO_RECALC_EN
   logic have_op_q;
   op_t  last_op_q;
`endif

   // Edges are masked for the first cycle after reset so a held button never fires.
   assign edges    = armed_q ? (button & ~btn_q) : 5'b0;
   assign clr_edge = edges[0];

   // Button history for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         btn_q   <= button;
         armed_q <= 1'b1;
      end
   end

   // Pick the highest-priority operation request.
   always_comb begin
      op_start = 1'b0;
      op_sel   = ADD;
      if (edges[1]) begin
         op_start = 1'b1;
         op_sel   = ADD;
      end else if (edges[2]) begin
         op_start = 1'b1;
         op_sel   = MUL;
      end else if (edges[3]) begin
         op_start = 1'b1;
         op_sel   = DIV;
      end else if (edges[4]) begin
         op_start = 1'b1;
         op_sel   = MOD;
      end
`ifdef CALC_AUTO_RECALC_EN
      else if (have_op_q && ((a != a_q) || (b != b_q))) begin
         op_start = 1'b1;
         op_sel   = last_op_q;
      end
`endif
   end

   assign start = (state_q == IDLE) && !clr_edge && op_start;

`ifdef CALC_AUTO_RECALC_EN
   // Remember the last started operation until a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_op_q <= 1'b0;
         last_op_q <= ADD;
      end else if (clr_edge) begin
         have_op_q <= 1'b0;
      end else if (start) begin
         have_op_q <= 1'b1;
         last_op_q <= op_sel;
      end
   end
`endif

   // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
   always_comb begin
      ma = a[WIDTH-1] ? -a : a;
      mb = b[WIDTH-1] ? -b : b;
   end

   // Arithmetic step logic shared by all operations.
   always_comb begin
      sum     = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
      sum_mag = sum[WIDTH] ? -sum : sum;
      acc_nx  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      rem_sh  = {rem_q, quot_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, dvsr_q};
      dz      = ((op_q == DIV) || (op_q == MOD)) && (b_q == '0);
      compute_last = (op_q == ADD) || dz || (cnt_q == CW'(WIDTH - 1));
   end

   // Operand sampling and iterative multiply/divide datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= ADD;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         dvsr_q   <= '0;
      end else if (start) begin
         a_q      <= a;
         b_q      <= b;
         op_q     <= op_sel;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= BW'(ma);
         mplier_q <= mb;
         quot_q   <= ma;
         rem_q    <= '0;
         dvsr_q   <= mb;
      end else if (state_q == COMPUTE) begin
         cnt_q    <= compute_last ? '0 : cnt_q + 1'b1;
         acc_q    <= acc_nx;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         // Restoring division: quotient bits shift in as dividend bits shift out.
         if (!diff[WIDTH]) begin
            rem_q  <= diff[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q  <= rem_sh[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
         end
      end else if (state_q == CONVERT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Select the final magnitude and sign of the finished operation.
   always_comb begin
      conv_bin = '0;
      res_neg  = 1'b0;
      unique case (op_q)
         ADD: begin
            conv_bin = BW'(sum_mag);
            res_neg  = sum[WIDTH];
         end
         MUL: begin
            conv_bin = acc_q;
            res_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
         end
         DIV: begin
            conv_bin = BW'(quot_q);
            res_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
         end
         MOD: begin
            conv_bin = BW'(rem_q);
            res_neg  = a_q[WIDTH-1];
         end
         default: ;
      endcase
      if (dz) conv_bin = '0;
      res_err = dz || (64'(conv_bin) > LIMIT);
   end

   assign conv_start = (state_q == CONVERT) && (cnt_q == '0);

   bin2bcd #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clr_edge),
      .start (conv_start),
      .bin   (conv_bin),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and status outputs; clear overrides everything.
   always_comb begin
      state_d = state_q;
      busy    = (state_q == COMPUTE) || (state_q == CONVERT);
      valid   = (state_q == DONE);
      unique case (state_q)
         IDLE:    if (start) state_d = COMPUTE;
         COMPUTE: if (compute_last) state_d = CONVERT;
         CONVERT: if (conv_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clr_edge) state_d = IDLE;
   end

   // Result registers: load on entry to DONE, zero on clear, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q <= '0;
         neg_q <= 1'b0;
         err_q <= 1'b0;
      end else if (clr_edge) begin
         bcd_q <= '0;
         neg_q <= 1'b0;
         err_q <= 1'b0;
      end else if ((state_q == CONVERT) && conv_done) begin
         bcd_q <= res_err ? {DIGITS{ERR_DIGIT}} : conv_bcd;
         neg_q <= !dz && res_neg && (conv_bin != '0);
         err_q <= res_err;
      end
   end

   assign bcd = bcd_q;
   assign neg = neg_q;
   assign err = err_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Scoreboard bench for seq_calculator (WIDTH=8, DIGITS=4): stimulus pushes the
// hand-computed response, a forked monitor pops and compares on each valid.
module tb_seq_calculator;

   typedef struct {
      string       tag;
      logic [15:0] bcd;
      logic        neg;
      logic        err;
      int          lat;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic signed [7:0] a, b;
   logic [4:0]        button;
   logic [15:0]       bcd;
   logic              neg, err, busy, valid;

   exp_t exp_q[$];
   int   total;
   int   bad;
   int   valid_count;
   int   busy_run;

   seq_calculator #(
      .WIDTH  (8),
      .DIGITS (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .button (button),
      .bcd    (bcd),
      .neg    (neg),
      .err    (err),
      .busy   (busy),
      .valid  (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_run = 0;
         end else if (valid) begin
            valid_count++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: got bcd=%h neg=%b err=%b, required no pulse",
                        bcd, neg, err);
            end else begin
               e = exp_q.pop_front();
               check({e.tag, "_bcd"}, 32'(bcd), 32'(e.bcd));
               check({e.tag, "_neg"}, 32'(neg), 32'(e.neg));
               check({e.tag, "_err"}, 32'(err), 32'(e.err));
               check({e.tag, "_busy_cycles"}, busy_run, e.lat);
            end
            busy_run = 0;
         end else if (busy) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Issue one operation; operands are disturbed after sampling and restored
   // before the result, so only the sampled values can affect it.
   task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [4:0] btn, input int hold, input logic [15:0] ebcd,
                        input logic eneg, input logic eerr, input int elat);
      exp_t e;
      e.tag = tag; e.bcd = ebcd; e.neg = eneg; e.err = eerr; e.lat = elat;
      @(negedge clk);
      a = ta; b = tb_v; button = btn;
      exp_q.push_back(e);
      @(negedge clk);
      a = ~ta; b = ta ^ 8'h5A;
      @(negedge clk);
      a = ta; b = tb_v;
      repeat (hold) @(negedge clk);
      button = 5'b0;
      wait_drain(80);
      repeat (2) @(negedge clk);
      check({tag, "_stable"}, 32'(bcd), 32'(ebcd));
   endtask

   initial begin
      int vc;
      total = 0; bad = 0; valid_count = 0; busy_run = 0;
      rst_n = 1'b0; button = 5'b0; a = '0; b = '0;
      fork
         monitor();
      join_none
      repeat (2) @(negedge clk);
      check("rst_bcd", 32'(bcd), 0);
      check("rst_neg", 32'(neg), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(valid), 0);
      rst_n = 1'b1;

      //     tag        a       b      button   hold  bcd      neg   err   busy
      do_op("add",     -8'sd5,  8'sd3,  5'b00010, 0, 16'h0002, 1'b1, 1'b0, 17);
      do_op("mul_ovf", -8'sd128, -8'sd128, 5'b00100, 0, 16'hFFFF, 1'b0, 1'b1, 24);
      do_op("div_neg", -8'sd7,  8'sd2,  5'b01000, 0, 16'h0003, 1'b1, 1'b0, 24);
      do_op("mod_neg", -8'sd7,  8'sd2,  5'b10000, 0, 16'h0001, 1'b1, 1'b0, 24);
      do_op("div_zero", 8'sd9,  8'sd0,  5'b01000, 0, 16'hFFFF, 1'b0, 1'b1, 17);
      do_op("prio",     8'sd10, -8'sd4, 5'b01010, 0, 16'h0006, 1'b0, 1'b0, 17);
      do_op("mul_neg",  8'sd12, -8'sd11, 5'b00100, 0, 16'h0132, 1'b1, 1'b0, 24);
      do_op("div_pos",  8'sd100, 8'sd7, 5'b01000, 0, 16'h0014, 1'b0, 1'b0, 24);
      do_op("mod_big", -8'sd100, 8'sd7, 5'b10000, 0, 16'h0002, 1'b1, 1'b0, 24);
      do_op("add_min", -8'sd128, -8'sd128, 5'b00010, 40, 16'h0256, 1'b1, 1'b0, 17);
      do_op("mul_zero", 8'sd0, -8'sd5,  5'b00100, 0, 16'h0000, 1'b0, 1'b0, 24);
      do_op("mod_zero", 8'sd6, -8'sd3,  5'b10000, 0, 16'h0000, 1'b0, 1'b0, 24);
      do_op("mul_max",  8'sd99, -8'sd101, 5'b00100, 0, 16'h9999, 1'b1, 1'b0, 24);
      do_op("mul_lim",  8'sd100, 8'sd100, 5'b00100, 0, 16'hFFFF, 1'b0, 1'b1, 24);

      // Reset in the middle of a multiply: immediate idle, no result.
      do_op("pre_rst", 8'sd7, 8'sd6, 5'b00100, 0, 16'h0042, 1'b0, 1'b0, 24);
      vc = valid_count;
      @(negedge clk); a = 8'sd3; b = 8'sd3; button = 5'b00100;
      @(negedge clk); button = 5'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_abort_busy", 32'(busy), 0);
      check("rst_abort_bcd", 32'(bcd), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_abort_no_valid", valid_count, vc);

      // Clear five cycles after a multiply edge.
      do_op("pre_clr", 8'sd12, -8'sd11, 5'b00100, 0, 16'h0132, 1'b1, 1'b0, 24);
      vc = valid_count;
      @(negedge clk); a = 8'sd5; b = 8'sd5; button = 5'b00100;
      @(negedge clk); button = 5'b0;
      repeat (4) @(negedge clk);
      button = 5'b00001;
      @(negedge clk);
      check("clr_busy", 32'(busy), 0);
      check("clr_bcd", 32'(bcd), 0);
      check("clr_neg", 32'(neg), 0);
      button = 5'b0;
      repeat (40) @(negedge clk);
      check("clr_no_valid", valid_count, vc);

      // Button held through reset release must not start anything.
      vc = valid_count;
      @(negedge clk); rst_n = 1'b0; a = 8'sd1; b = 8'sd1; button = 5'b00010;
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("held_busy", 32'(busy), 0);
      button = 5'b0;
      repeat (30) @(negedge clk);
      check("held_no_valid", valid_count, vc);

      do_op("add_after", 8'sd1, 8'sd2, 5'b00010, 0, 16'h0003, 1'b0, 1'b0, 17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
